// File: rtl/load_unit_if.sv
// Load unit bundle: execute-side request, data-memory read port, writeback result.
// slave is the load unit's view; master is the environment (execute, memory, writeback).
// Every channel is valid/ready; the memory response has valid only (no backpressure).
interface load_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    // execute -> load unit
    logic             io_req_valid;
    logic             io_req_ready;
    logic [XLEN-1:0]  io_req_addr;
    logic [2:0]       io_req_funct3;
    logic [TAG_W-1:0] io_req_tag;
    // load unit <-> data memory
    logic             io_mem_req_valid;
    logic             io_mem_req_ready;
    logic [XLEN-1:0]  io_mem_addr;
    logic             io_mem_resp_valid;
    logic [XLEN-1:0]  io_mem_rdata;
    // load unit -> writeback
    logic             io_resp_valid;
    logic             io_resp_ready;
    logic [XLEN-1:0]  io_resp_data;
    logic [TAG_W-1:0] io_resp_tag;
    logic             io_resp_misaligned;
    logic             io_resp_illegal;

    modport slave (
        input  io_req_valid, io_req_addr, io_req_funct3, io_req_tag,
        input  io_mem_req_ready, io_mem_resp_valid, io_mem_rdata,
        input  io_resp_ready,
        output io_req_ready, io_mem_req_valid, io_mem_addr,
        output io_resp_valid, io_resp_data, io_resp_tag,
        output io_resp_misaligned, io_resp_illegal
    );

    modport master (
        output io_req_valid, io_req_addr, io_req_funct3, io_req_tag,
        output io_mem_req_ready, io_mem_resp_valid, io_mem_rdata,
        output io_resp_ready,
        input  io_req_ready, io_mem_req_valid, io_mem_addr,
        input  io_resp_valid, io_resp_data, io_resp_tag,
        input  io_resp_misaligned, io_resp_illegal
    );
endinterface

// File: rtl/load_unit.sv
// Load unit: issues a word-aligned read, extracts/extends the addressed lane, returns it with its tag.
// Latency: zero-wait memory gives accept T, mem req T+1, mem resp T+2, result T+3; faults give result T+1.
// Backpressure: one load in flight; io_req_ready only in IDLE, request/result held stable until their handshakes.
// Ports: clock, reset (async active-high); io = load_unit_if.slave carrying the request, memory and result channels.
module load_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic          clock,
    input  logic          reset,
    load_unit_if.slave    io
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic             misaligned_q, misaligned_d;
    logic             illegal_q, illegal_d;

    logic             req_illegal;
    logic             req_misaligned;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [XLEN-1:0]  fmt_data;

    // Decode faults straight from the incoming request so the fault path can skip memory.
    always_comb begin
        req_illegal    = (io.io_req_funct3 == 3'b011) || (io.io_req_funct3 == 3'b110) ||
                         (io.io_req_funct3 == 3'b111);
        req_misaligned = 1'b0;
        if (!req_illegal) begin
            if (io.io_req_funct3[1:0] == 2'b01)
                req_misaligned = io.io_req_addr[0];
            else if (io.io_req_funct3[1:0] == 2'b10)
                req_misaligned = (io.io_req_addr[1:0] != 2'b00);
        end
    end

    // Lane extraction from the returned little-endian word using the captured request.
    always_comb begin
        byte_sel = 8'h00;
        case (addr_q[1:0])
            2'd0:    byte_sel = io.io_mem_rdata[7:0];
            2'd1:    byte_sel = io.io_mem_rdata[15:8];
            2'd2:    byte_sel = io.io_mem_rdata[23:16];
            default: byte_sel = io.io_mem_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? io.io_mem_rdata[31:16] : io.io_mem_rdata[15:0];
        fmt_data = '0;
        case (funct3_q)
            3'b000:  fmt_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001:  fmt_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b010:  fmt_data = io.io_mem_rdata;
            3'b100:  fmt_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101:  fmt_data = {{(XLEN-16){1'b0}}, half_sel};
            default: fmt_data = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        tag_d        = tag_q;
        data_d       = data_q;
        misaligned_d = misaligned_q;
        illegal_d    = illegal_q;
        case (state_q)
            IDLE: begin
                if (io.io_req_valid) begin
                    addr_d       = io.io_req_addr;
                    funct3_d     = io.io_req_funct3;
                    tag_d        = io.io_req_tag;
                    data_d       = '0;
                    misaligned_d = req_misaligned;
                    illegal_d    = req_illegal;
                    state_d      = (req_illegal || req_misaligned) ? RESP : REQ;
                end
            end
            REQ: begin
                if (io.io_mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (io.io_mem_resp_valid) begin
                    data_d  = fmt_data;
                    state_d = RESP;
                end
            end
            default: begin
                if (io.io_resp_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            tag_q        <= '0;
            data_q       <= '0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            misaligned_q <= misaligned_d;
            illegal_q    <= illegal_d;
        end
    end

    // Ready is withheld while reset is asserted even though the state already reads IDLE.
    assign io.io_req_ready       = (state_q == IDLE) && !reset;
    assign io.io_mem_req_valid   = (state_q == REQ);
    assign io.io_mem_addr        = {addr_q[XLEN-1:2], 2'b00};
    assign io.io_resp_valid      = (state_q == RESP);
    assign io.io_resp_data       = data_q;
    assign io.io_resp_tag        = tag_q;
    assign io.io_resp_misaligned = misaligned_q;
    assign io.io_resp_illegal    = illegal_q;
endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;
    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        mis;
        logic        ill;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb_q[$];

    // memory model controls
    int          mem_stall = 0;
    int          mem_dly = 0;
    int          stall_cnt = 0;
    int          resp_cnt = -1;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] exp_mem_addr = 32'h100;
    logic        mem_forbid = 1'b0;

    load_unit_if #(.XLEN(32), .TAG_W(5)) lif ();

    load_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .io    (lif)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a == 32'h100) return 32'h8899AABB;
        if (a == 32'h200) return 32'h12345678;
        return 32'hDEADBEEF;
    endfunction

    // Data memory: stalls the request mem_stall cycles, answers mem_dly+1 cycles after the handshake.
    always @(negedge clock) begin
        lif.io_mem_resp_valid = 1'b0;
        if (resp_cnt == 0) begin
            lif.io_mem_resp_valid = 1'b1;
            lif.io_mem_rdata      = mem_read(pend_addr);
            resp_cnt              = -1;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
        end
        if (mem_forbid) check("mem_req_forbidden", {31'd0, lif.io_mem_req_valid}, 32'd0);
        if (reset || !lif.io_mem_req_valid) begin
            lif.io_mem_req_ready = 1'b0;
        end else if (stall_cnt < mem_stall) begin
            lif.io_mem_req_ready = 1'b0;
            stall_cnt++;
        end else begin
            lif.io_mem_req_ready = 1'b1;
            stall_cnt            = 0;
            resp_cnt             = mem_dly;
            pend_addr            = lif.io_mem_addr;
            check("mem_addr", lif.io_mem_addr, exp_mem_addr);
        end
    end

    // Writeback monitor: every result handshake pops the scoreboard.
    always @(negedge clock) begin
        if (!reset && lif.io_resp_valid && lif.io_resp_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", 32'(sb_q.size() + 1), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("resp_data", lif.io_resp_data, e.data);
                check("resp_tag", {27'd0, lif.io_resp_tag}, {27'd0, e.tag});
                check("resp_mis", {31'd0, lif.io_resp_misaligned}, {31'd0, e.mis});
                check("resp_ill", {31'd0, lif.io_resp_illegal}, {31'd0, e.ill});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [4:0] t, input logic m, input logic i);
        exp_t e;
        e.data = d; e.tag = t; e.mis = m; e.ill = i;
        sb_q.push_back(e);
    endtask

    // Presents a request and returns in the cycle after acceptance (T+1), valid dropped.
    task automatic send(input logic [31:0] a, input logic [2:0] f, input logic [4:0] t);
        int n = 0;
        lif.io_req_addr   = a;
        lif.io_req_funct3 = f;
        lif.io_req_tag    = t;
        lif.io_req_valid  = 1'b1;
        while (!lif.io_req_ready && n < 20) begin
            tick();
            n++;
        end
        check("accept_timeout", {31'd0, lif.io_req_ready}, 32'd1);
        tick();
        lif.io_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || !lif.io_req_ready) && n < 60) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic load_zw(input logic [31:0] a, input logic [2:0] f, input logic [4:0] t,
                           input logic [31:0] d);
        push_exp(d, t, 1'b0, 1'b0);
        send(a, f, t);
        check("lat_mem_req_t1", {31'd0, lif.io_mem_req_valid}, 32'd1);
        tick();
        check("lat_resp_t2", {31'd0, lif.io_resp_valid}, 32'd0);
        tick();
        check("lat_resp_t3", {31'd0, lif.io_resp_valid}, 32'd1);
        drain();
    endtask

    task automatic fault(input logic [31:0] a, input logic [2:0] f, input logic [4:0] t,
                         input logic m, input logic i);
        mem_forbid = 1'b1;
        push_exp(32'h0, t, m, i);
        send(a, f, t);
        check("fault_resp_t1", {31'd0, lif.io_resp_valid}, 32'd1);
        drain();
        mem_forbid = 1'b0;
    endtask

    initial begin
        logic [31:0] held_data;
        logic [4:0]  held_tag;
        int          n;
        int          last_acc;
        logic [31:0] b2b_addr [4];
        logic [31:0] b2b_data [4];

        lif.io_req_valid      = 1'b0;
        lif.io_req_addr       = 32'h0;
        lif.io_req_funct3     = 3'b000;
        lif.io_req_tag        = 5'd0;
        lif.io_resp_ready     = 1'b1;
        lif.io_mem_req_ready  = 1'b0;
        lif.io_mem_resp_valid = 1'b0;
        lif.io_mem_rdata      = 32'h0;
        repeat (2) tick();
        check("rst_resp_valid", {31'd0, lif.io_resp_valid}, 32'd0);
        check("rst_mem_req_valid", {31'd0, lif.io_mem_req_valid}, 32'd0);
        check("rst_resp_data", lif.io_resp_data, 32'd0);
        check("rst_resp_tag", {27'd0, lif.io_resp_tag}, 32'd0);
        check("rst_flags", {30'd0, lif.io_resp_misaligned, lif.io_resp_illegal}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_req_ready", {31'd0, lif.io_req_ready}, 32'd1);
        tick();

        // lane selection and extension, zero-wait memory
        load_zw(32'h101, 3'b000, 5'd1, 32'hFFFFFFAA);
        load_zw(32'h103, 3'b100, 5'd2, 32'h00000088);
        load_zw(32'h102, 3'b001, 5'd3, 32'hFFFF8899);
        load_zw(32'h100, 3'b101, 5'd4, 32'h0000AABB);
        load_zw(32'h100, 3'b010, 5'd5, 32'h8899AABB);

        // fault path
        fault(32'h101, 3'b001, 5'd6, 1'b1, 1'b0);
        fault(32'h102, 3'b010, 5'd7, 1'b1, 1'b0);
        fault(32'h100, 3'b011, 5'd8, 1'b0, 1'b1);

        // memory stalls: 4 cycles of ready low, response 3 cycles after the handshake
        mem_stall = 4;
        mem_dly   = 2;
        push_exp(32'hFFFF8899, 5'd10, 1'b0, 1'b0);
        send(32'h102, 3'b001, 5'd10);
        n = 0;
        while (!lif.io_resp_valid && n < 40) begin
            check("stall_req_ready", {31'd0, lif.io_req_ready}, 32'd0);
            if (lif.io_mem_req_valid) check("stall_mem_addr", lif.io_mem_addr, 32'h100);
            tick();
            n++;
        end
        check("stall_latency", n, 32'd8);
        drain();
        mem_stall = 0;
        mem_dly   = 0;

        // writeback backpressure with a competing request
        lif.io_resp_ready = 1'b0;
        push_exp(32'h8899AABB, 5'd9, 1'b0, 1'b0);
        send(32'h100, 3'b010, 5'd9);
        n = 0;
        while (!lif.io_resp_valid && n < 20) begin
            tick();
            n++;
        end
        held_data         = lif.io_resp_data;
        held_tag          = lif.io_resp_tag;
        lif.io_req_addr   = 32'h103;
        lif.io_req_funct3 = 3'b100;
        lif.io_req_tag    = 5'd3;
        lif.io_req_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_valid", {31'd0, lif.io_resp_valid}, 32'd1);
            check("bp_resp_data", lif.io_resp_data, 32'h8899AABB);
            check("bp_resp_tag", {27'd0, lif.io_resp_tag}, 32'd9);
            check("bp_req_ready", {31'd0, lif.io_req_ready}, 32'd0);
            tick();
        end
        check("bp_held_data", lif.io_resp_data, held_data);
        check("bp_held_tag", {27'd0, lif.io_resp_tag}, {27'd0, held_tag});
        lif.io_req_valid  = 1'b0;
        lif.io_resp_ready = 1'b1;
        drain();

        // reset while in WAIT; the late memory response must be dropped
        mem_dly = 3;
        send(32'h100, 3'b010, 5'd11);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst_wait_resp_valid", {31'd0, lif.io_resp_valid}, 32'd0);
            check("rst_wait_req_ready", {31'd0, lif.io_req_ready}, 32'd1);
        end
        mem_dly      = 0;
        exp_mem_addr = 32'h200;
        push_exp(32'h12345678, 5'd12, 1'b0, 1'b0);
        send(32'h200, 3'b010, 5'd12);
        drain();

        // back-to-back LBs with valid held high
        exp_mem_addr = 32'h100;
        b2b_addr = '{32'h100, 32'h101, 32'h102, 32'h103};
        b2b_data = '{32'hFFFFFFBB, 32'hFFFFFFAA, 32'hFFFFFF99, 32'hFFFFFF88};
        for (int k = 0; k < 4; k++) push_exp(b2b_data[k], 5'(20 + k), 1'b0, 1'b0);
        lif.io_req_addr   = b2b_addr[0];
        lif.io_req_funct3 = 3'b000;
        lif.io_req_tag    = 5'd20;
        lif.io_req_valid  = 1'b1;
        last_acc = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!lif.io_req_ready && n < 20) begin
                tick();
                n++;
            end
            check("b2b_accept", {31'd0, lif.io_req_ready}, 32'd1);
            if (k > 0) check("b2b_spacing", cyc - last_acc, 32'd4);
            last_acc = cyc;
            tick();
            if (k < 3) begin
                lif.io_req_addr = b2b_addr[k + 1];
                lif.io_req_tag  = 5'(21 + k);
            end else begin
                lif.io_req_valid = 1'b0;
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
